// File: rtl/cc_muxn1_arb.sv
// N:1 valid/ready multiplexer with round-robin arbitration and one registered output stage.
// Define CC_MUXN1_FIXEDPRIO_EN for fixed lowest-index priority instead of round robin.
module cc_muxn1_arb #(
    parameter int MUXN1_DATAWIDTH = 8,
    parameter int MUXN1_NUMCH     = 4,
    parameter int MUXN1_CHWIDTH   = 2
) (
    input  logic                                   CC_MUXN1_CLOCK_50,
    input  logic                                   CC_MUXN1_RESET_InHigh,
    input  logic [MUXN1_NUMCH*MUXN1_DATAWIDTH-1:0] CC_MUXN1_data_InBUS,
    input  logic [MUXN1_NUMCH-1:0]                 CC_MUXN1_valid_InBUS,
    output logic [MUXN1_NUMCH-1:0]                 CC_MUXN1_ready_OutBUS,
    output logic [MUXN1_DATAWIDTH-1:0]             CC_MUXN1_data_OutBUS,
    output logic [MUXN1_CHWIDTH-1:0]               CC_MUXN1_chan_OutBUS,
    output logic                                   CC_MUXN1_valid_Out,
    input  logic                                   CC_MUXN1_ready_In
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                     state;
    logic [MUXN1_CHWIDTH-1:0]   ptr;
    logic                       load_en;
    logic                       grant_any;
    logic [MUXN1_CHWIDTH-1:0]   grant_idx;

    // Rotating search starting at ptr; the first valid channel found wins.
    // NOTE: every always_comb output gets a default before the loop, otherwise paths
    // that skip an assignment would infer a latch.
    always_comb begin
        int idx;
        idx                   = 0;
        load_en               = (state == EMPTY) || CC_MUXN1_ready_In;
        grant_any             = 1'b0;
        grant_idx             = '0;
        CC_MUXN1_ready_OutBUS = '0;
        for (int i = 0; i < MUXN1_NUMCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= MUXN1_NUMCH) begin
                idx = idx - MUXN1_NUMCH;
            end
            if (load_en && !grant_any && CC_MUXN1_valid_InBUS[idx]) begin
                grant_any = 1'b1;
                grant_idx = MUXN1_CHWIDTH'(idx);
            end
        end
        if (grant_any) begin
            CC_MUXN1_ready_OutBUS[grant_idx] = 1'b1;
        end
    end

`ifndef CC_MUXN1_FIXEDPRIO_EN
    logic [MUXN1_CHWIDTH-1:0] next_ptr;
    assign next_ptr = (grant_idx == MUXN1_CHWIDTH'(MUXN1_NUMCH - 1)) ? '0 : grant_idx + 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CC_MUXN1_CLOCK_50) begin
        if (CC_MUXN1_RESET_InHigh) begin
            state                <= EMPTY;
            CC_MUXN1_data_OutBUS <= '0;
            CC_MUXN1_chan_OutBUS <= '0;
            ptr                  <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                state                <= FULL;
                CC_MUXN1_data_OutBUS <= CC_MUXN1_data_InBUS[grant_idx*MUXN1_DATAWIDTH +: MUXN1_DATAWIDTH];
                CC_MUXN1_chan_OutBUS <= grant_idx;
`ifndef CC_MUXN1_FIXEDPRIO_EN
                ptr                  <= next_ptr;
`endif
            end else begin
                // Drain: word leaves, data/chan/ptr hold their last values.
                state <= EMPTY;
            end
        end
    end

    assign CC_MUXN1_valid_Out = (state == FULL);

endmodule
